// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core and the UART transmitter, with show-ahead head byte,
// fill-level flags and a sticky overflow flag for bytes dropped while full.
module uart_tx_fifo #(
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              valid_send,
  output logic [7:0]        data_send,
  input  logic              ready_send
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = (ADDR_W)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   count_nxt;

  // Both handshakes are judged from registered state only, so a pop never
  // depends on ready_send dropping and a full FIFO rejects the push outright.
  assign push = wr_en && !full;
  assign pop  = valid_send && ready_send;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + ONE_CNT;
      2'b01:   count_nxt = count - ONE_CNT;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign data_send = mem[rd_ptr];

  // Flags are compared against the next count so they move on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      valid_send  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)
        rd_ptr <= rd_ptr + ONE_PTR;
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_CNT);
      almost_full <= (count_nxt >= AFULL_CNT);
      valid_send  <= (count_nxt != '0);
      if (wr_en && full)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted pushes queue expected bytes, and a
// negedge monitor checks every byte the transmitter takes against that queue.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       overflow_clr;
  logic       valid_send;
  logic [7:0] data_send;
  logic       ready_send;

  int         checks = 0;
  int         errors = 0;
  int         model_count = 0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.ADDR_W(4), .AFULL_LVL(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .valid_send   (valid_send),
    .data_send    (data_send),
    .ready_send   (ready_send)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; the model decides what the FIFO should accept.
  task automatic applyStimulus(input logic we, input logic [7:0] data,
                               input logic rdy, input logic clr);
    bit push_ok;
    bit pop_ok;
    wr_en        = we;
    wr_data      = data;
    ready_send   = rdy;
    overflow_clr = clr;
    push_ok = we && (model_count < 16);
    pop_ok  = rdy && (model_count != 0);
    if (push_ok) exp_q.push_back(data);
    model_count = model_count + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
    wr_en        = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    ready_send   = 1'b0;
    overflow_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_count = 0;
    exp_q.delete();
  endtask

  // Monitor: a pop happens on the coming posedge whenever valid && ready now.
  always @(negedge clk) begin
    if (!rst && valid_send && ready_send) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no byte", data_send);
      end else begin
        checkOutput("pop_data", int'(data_send), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    doReset();

    // 1: reset state, single byte through
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_afull", int'(almost_full), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_valid", int'(valid_send), 0);
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
    checkOutput("t1_valid", int'(valid_send), 1);
    checkOutput("t1_data", int'(data_send), 'h41);
    checkOutput("t1_count", int'(count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t1_count_after", int'(count), 0);
    checkOutput("t1_valid_after", int'(valid_send), 0);

    // 2: fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) checkOutput("t2_afull_11", int'(almost_full), 0);
      if (i == 11) checkOutput("t2_afull_12", int'(almost_full), 1);
      if (i == 14) checkOutput("t2_full_15", int'(full), 0);
    end
    checkOutput("t2_full", int'(full), 1);
    checkOutput("t2_count", int'(count), 16);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("t2_overflow", int'(overflow), 1);
    checkOutput("t2_count_ovf", int'(count), 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t2_drained", int'(count), 0);
    checkOutput("t2_ovf_sticky", int'(overflow), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2_ovf_clr", int'(overflow), 0);

    // 3: simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("t3_count", int'(count), 5);
    checkOutput("t3_head", int'(data_send), 'h51);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t3_drained", int'(count), 0);

    // 4: push and pop together while full
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("t4_overflow", int'(overflow), 1);
    checkOutput("t4_count", int'(count), 15);
    checkOutput("t4_full", int'(full), 0);
    checkOutput("t4_head", int'(data_send), 'h61);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4_drained", int'(count), 0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("t4_ovf_clr", int'(overflow), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: pointer wrap while streaming
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
    checkOutput("t5_stream_count", int'(count), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_drained", int'(count), 0);

    // 6: reset while loaded and mid-frame
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_count_pre", int'(count), 7);
    doReset();
    checkOutput("t6_count_rst", int'(count), 0);
    checkOutput("t6_valid_rst", int'(valid_send), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hD5, 1'b1, 1'b0);
    checkOutput("t6_new_data", int'(data_send), 'hD5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t6_count_end", int'(count), 0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
